fetch_ctrl: RTL and testbench

- Instruction-fetch control FSM and the driving end of the program counter's ld/incr/Din interface.
- Reads the current PC value and runs a request/ack read on instruction memory.
- Latches the returned word into the instruction register and presents it to decode with a valid/ready handshake.
- Pulses incr to advance the PC, or ld with a branch target to redirect it.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_timer.sv | 44 ++++
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encoding plus default widths and the ack-wait limit.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_REDIR = 3'd4
    } state_t;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/fetch_timer.sv
// Ack-wait cycle counter for fetch_ctrl. clr_i zeroes the count, en_i
// advances it, expired_o flags the TIMEOUT-th cycle since the last clear.
// Only present when FETCH_TIMEOUT_EN is defined, matching its only user.
`ifdef FETCH_TIMEOUT_EN
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned    CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == LAST);

    // Count cycles since the last clear, saturating at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control FSM: reads the PC, runs a req/ack read on
// instruction memory, holds the word in ir for decode (valid/ready) and
// drives the PC's incr/ld/din interface. Optional ack-wait limit with a
// sticky error flag is compiled in when FETCH_TIMEOUT_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_incr,
    output logic              pc_ld,
    output logic [ADDR_W-1:0] pc_din,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] pc_din_q, pc_din_d;
    logic              pc_incr_q, pc_incr_d;
    logic              err_q, err_d;
    logic              tmo;

`ifdef FETCH_TIMEOUT_EN
    // Counter restarts on every state change, so REQ and DRAIN each get a
    // full TIMEOUT window from their own entry.
    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_d != state_q),
        .en_i      ((state_q == ST_REQ) || (state_q == ST_DRAIN)),
        .expired_o (tmo)
    );
`else
    assign tmo = 1'b0;
    // TIMEOUT has no effect without the ack-wait limit; this guard keeps it referenced.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Outputs: registered values or pure decode of the current state.
    assign mem_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign ir_valid  = (state_q == ST_HOLD);
    assign pc_ld     = (state_q == ST_REDIR);
    assign pc_incr   = pc_incr_q;
    assign pc_din    = pc_din_q;
    assign mem_addr  = mem_addr_q;
    assign ir        = ir_q;
    assign fetch_err = err_q;

    // Next-state and datapath-capture decode.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        mem_addr_d = mem_addr_q;
        pc_din_d   = pc_din_q;
        pc_incr_d  = 1'b0;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (br_req) begin
                    pc_din_d = br_target;
                    state_d  = ST_REDIR;
                end else if (fetch_en && !err_q) begin
                    mem_addr_d = pc_addr;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (br_req) begin
                    // A same-cycle ack is dropped: the read belongs to the old path.
                    pc_din_d = br_target;
                    state_d  = mem_ack ? ST_REDIR : ST_DRAIN;
                end else if (mem_ack) begin
                    ir_d      = mem_rdata;
                    pc_incr_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (br_req) begin
                    pc_din_d = br_target;
                    state_d  = ST_REDIR;
                end else if (ir_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (br_req) begin
                    pc_din_d = br_target;
                end
                if (mem_ack) begin
                    state_d = ST_REDIR;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (br_req) begin
                    pc_din_d = br_target;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            mem_addr_q <= '0;
            pc_din_q   <= '0;
            pc_incr_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            mem_addr_q <= mem_addr_d;
            pc_din_q   <= pc_din_d;
            pc_incr_q  <= pc_incr_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a simple PC model and an
// expected-instruction scoreboard. Timeout checks run when
// FETCH_TIMEOUT_EN is defined.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [15:0] pc_addr;
    logic        pc_incr;
    logic        pc_ld;
    logic [15:0] pc_din;
    logic        br_req;
    logic [15:0] br_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb[$];

    logic        pc_set;
    logic [15:0] pc_set_val;
    logic [15:0] pc_model;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_en  (fetch_en),
        .pc_addr   (pc_addr),
        .pc_incr   (pc_incr),
        .pc_ld     (pc_ld),
        .pc_din    (pc_din),
        .br_req    (br_req),
        .br_target (br_target),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .fetch_err (fetch_err)
    );

    // Program counter: updates one edge after incr/ld, as the real PC does.
    always @(posedge clk) begin
        if (pc_set)       pc_model <= pc_set_val;
        else if (pc_ld)   pc_model <= pc_din;
        else if (pc_incr) pc_model <= pc_model + 16'd1;
    end
    assign pc_addr = pc_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on each delivered instruction, plus incr/ld exclusivity.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("incr_ld_excl", {30'd0, pc_incr, pc_ld} == 32'd3, 32'd0);
            if (pc_incr === 1'b1) begin
                chk("sb_nonempty", sb.size() > 0, 32'd1);
                if (sb.size() > 0) chk("sb_ir", ir, sb.pop_front());
                chk("sb_ir_valid", ir_valid, 1);
            end
        end
    end

    task automatic wait_mem_req();
        int unsigned n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_wait", mem_req, 1);
    endtask

    // From IDLE: fetch, ack after ack_delay extra REQ cycles; returns in first HOLD cycle.
    task automatic do_fetch(input logic [15:0] exp_addr, input int unsigned ack_delay,
                            input logic [15:0] data);
        fetch_en = 1'b1;
        @(negedge clk);
        wait_mem_req();
        fetch_en = 1'b0;
        chk("fetch_addr", mem_addr, exp_addr);
        for (int unsigned i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            chk("req_held", mem_req, 1);
            chk("addr_held", mem_addr, exp_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        sb.push_back(data);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("hold_valid", ir_valid, 1);
        chk("hold_ir", ir, data);
        chk("hold_incr", pc_incr, 1);
        chk("hold_no_ld", pc_ld, 0);
        chk("hold_no_req", mem_req, 0);
    endtask

    task automatic accept();
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        chk("accept_valid", ir_valid, 0);
    endtask

    initial begin
        reset      = 1'b0;
        fetch_en   = 1'b0;
        br_req     = 1'b0;
        br_target  = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        ir_ready   = 1'b0;
        pc_set     = 1'b1;
        pc_set_val = 16'h0000;
        repeat (2) @(negedge clk);
        pc_set = 1'b0;

        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_pc_incr", pc_incr, 0);
        chk("rst_pc_ld", pc_ld, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pc_din", pc_din, 0);
        chk("rst_fetch_err", fetch_err, 0);
        reset = 1'b1;
        @(negedge clk);

        // Fetch at 0x0000, ack on the second REQ cycle.
        do_fetch(16'h0000, 1, 16'h1234);
        @(negedge clk);
        chk("incr_one_cycle", pc_incr, 0);

        // Decode stalls: ir held, no new request.
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_ir", ir, 16'h1234);
            chk("stall_valid", ir_valid, 1);
            chk("stall_no_req", mem_req, 0);
        end
        accept();

        // Best-case fetch at the incremented PC.
        do_fetch(16'h0001, 0, 16'hABCD);
        accept();

        // Redirect during REQ with a late ack: data dropped, then load.
        fetch_en = 1'b1;
        @(negedge clk);
        wait_mem_req();
        fetch_en = 1'b0;
        chk("br_fetch_addr", mem_addr, 16'h0002);
        br_req    = 1'b1;
        br_target = 16'h00A0;
        @(negedge clk);
        br_req = 1'b0;
        chk("drain_req", mem_req, 1);
        chk("drain_no_ld", pc_ld, 0);
        repeat (2) begin
            @(negedge clk);
            chk("drain_req_held", mem_req, 1);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("redir_ld", pc_ld, 1);
        chk("redir_din", pc_din, 16'h00A0);
        chk("redir_no_req", mem_req, 0);
        chk("redir_ir_kept", ir, 16'hABCD);
        chk("redir_no_valid", ir_valid, 0);
        @(negedge clk);
        chk("redir_one_cycle", pc_ld, 0);
        do_fetch(16'h00A0, 0, 16'h4321);
        accept();

        // Redirect and ack in the same REQ cycle.
        fetch_en = 1'b1;
        @(negedge clk);
        wait_mem_req();
        fetch_en  = 1'b0;
        chk("same_addr", mem_addr, 16'h00A1);
        br_req    = 1'b1;
        br_target = 16'h0200;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        br_req  = 1'b0;
        mem_ack = 1'b0;
        chk("same_no_incr", pc_incr, 0);
        chk("same_no_valid", ir_valid, 0);
        chk("same_ld", pc_ld, 1);
        chk("same_din", pc_din, 16'h0200);
        chk("same_ir_kept", ir, 16'h4321);
        @(negedge clk);
        chk("same_ld_done", pc_ld, 0);

        // Flush in HOLD (branch beats ready), then REDIR extension.
        do_fetch(16'h0200, 0, 16'h1111);
        br_req    = 1'b1;
        br_target = 16'h0300;
        ir_ready  = 1'b1;
        @(negedge clk);
        ir_ready  = 1'b0;
        br_target = 16'h0400;
        chk("flush_valid", ir_valid, 0);
        chk("flush_ld", pc_ld, 1);
        chk("flush_din", pc_din, 16'h0300);
        @(negedge clk);
        br_req = 1'b0;
        chk("ext_ld", pc_ld, 1);
        chk("ext_din", pc_din, 16'h0400);
        @(negedge clk);
        chk("ext_done", pc_ld, 0);
        do_fetch(16'h0400, 0, 16'h5555);
        accept();

        // PC wrap is transparent.
        pc_set     = 1'b1;
        pc_set_val = 16'hFFFF;
        @(negedge clk);
        pc_set = 1'b0;
        do_fetch(16'hFFFF, 0, 16'h2222);
        accept();
        do_fetch(16'h0000, 2, 16'h3333);
        accept();

        // Ack while idle is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack_valid", ir_valid, 0);
            chk("idle_ack_req", mem_req, 0);
            chk("idle_ack_ir", ir, 16'h3333);
        end
        mem_ack = 1'b0;
        chk("no_err", fetch_err, 0);

        // Asynchronous reset mid-request.
        fetch_en = 1'b1;
        @(negedge clk);
        wait_mem_req();
        fetch_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_addr", mem_addr, 0);
        chk("async_rst_ir", ir, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef FETCH_TIMEOUT_EN
        begin
            int unsigned cnt;
            pc_set     = 1'b1;
            pc_set_val = 16'h0010;
            @(negedge clk);
            pc_set   = 1'b0;
            fetch_en = 1'b1;
            @(negedge clk);
            wait_mem_req();
            cnt = 0;
            for (int unsigned i = 0; i < 40 && mem_req === 1'b1; i++) begin
                cnt++;
                @(negedge clk);
            end
            chk("tmo_req_cycles", cnt, 15);
            chk("tmo_err", fetch_err, 1);
            repeat (8) begin
                @(negedge clk);
                chk("tmo_no_req", mem_req, 0);
                chk("tmo_sticky", fetch_err, 1);
            end
            fetch_en = 1'b0;
            reset    = 1'b0;
            @(negedge clk);
            chk("tmo_rst_clear", fetch_err, 0);
            reset = 1'b1;
            @(negedge clk);

            // Timeout while draining still completes the redirect.
            fetch_en = 1'b1;
            @(negedge clk);
            wait_mem_req();
            fetch_en  = 1'b0;
            br_req    = 1'b1;
            br_target = 16'h0500;
            @(negedge clk);
            br_req = 1'b0;
            cnt = 0;
            for (int unsigned i = 0; i < 40 && mem_req === 1'b1; i++) begin
                cnt++;
                @(negedge clk);
            end
            chk("tmo_drain_cycles", cnt, 15);
            chk("tmo_drain_ld", pc_ld, 1);
            chk("tmo_drain_din", pc_din, 16'h0500);
            chk("tmo_drain_err", fetch_err, 1);
            @(negedge clk);
        end
`endif

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
